uart_frame_serializer: RTL and testbench

Parametrised UART transmit frame engine. Accepts a parallel word through a valid/ready handshake and emits one complete serial frame on TX_OUT: start bit, 5..MAX_DATA_WIDTH data bits, optional parity, and 1 or 2 stop bits. Bit order and frame format are selectable per frame. Bit timing comes from an external baud strobe TICK. The block sits between the TX data buffer and the line driver.

---
 rtl/uart_tx_pkg.sv | 17 +
 rtl/uart_frame_serializer_if.sv | 32 +++
 rtl/uart_parity_calc.sv | 21 ++
 rtl/uart_frame_serializer.sv | 158 +++++++++++++++
 tb/tb_uart_frame_serializer.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit path: frame states and frame-format constants.
package uart_tx_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_t;

   localparam int LEN_MIN = 5;

   localparam logic [1:0] STOP_BITS_ONE = 2'd1;
   localparam logic [1:0] STOP_BITS_TWO = 2'd2;

endpackage

// File: rtl/uart_frame_serializer_if.sv
// Word handshake, per-frame configuration and serial-line status between the TX buffer and the serializer.
interface uart_frame_serializer_if #(
   parameter int MAX_DATA_WIDTH = 9,
   parameter int CNT_WIDTH      = 4
);

   logic                      TICK;
   logic [MAX_DATA_WIDTH-1:0] P_DATA;
   logic                      DATA_VALID;
   logic                      DATA_READY;
   logic [CNT_WIDTH-1:0]      CFG_LEN;
   logic                      CFG_MSB_FIRST;
   logic                      CFG_PAR_EN;
   logic                      CFG_PAR_ODD;
   logic                      CFG_STOP2;
   logic                      TX_OUT;
   logic                      BUSY;
   logic                      FRAME_DONE;

   modport master (
      output TICK, P_DATA, DATA_VALID, CFG_LEN, CFG_MSB_FIRST,
             CFG_PAR_EN, CFG_PAR_ODD, CFG_STOP2,
      input  DATA_READY, TX_OUT, BUSY, FRAME_DONE
   );

   modport slave (
      input  TICK, P_DATA, DATA_VALID, CFG_LEN, CFG_MSB_FIRST,
             CFG_PAR_EN, CFG_PAR_ODD, CFG_STOP2,
      output DATA_READY, TX_OUT, BUSY, FRAME_DONE
   );

endinterface

// File: rtl/uart_parity_calc.sv
// Parity over the low 'len' bits of a data word; bits at or above len are masked out.
module uart_parity_calc #(
   parameter int DATA_WIDTH = 9,
   parameter int CNT_WIDTH  = 4
) (
   input  logic [DATA_WIDTH-1:0] data,
   input  logic [CNT_WIDTH-1:0]  len,
   input  logic                  odd,
   output logic                  parity
);

   always_comb begin
      parity = odd;
      for (int i = 0; i < DATA_WIDTH; i++) begin
         if (i < int'(len)) begin
            parity = parity ^ data[i];
         end
      end
   end

endmodule

// File: rtl/uart_frame_serializer.sv
// UART transmit frame engine: start bit, 5..MAX_DATA_WIDTH data bits, optional parity, 1 or 2 stop bits,
// one bit per TICK, with back-to-back frames accepted on the final stop-bit edge.
module uart_frame_serializer
   import uart_tx_pkg::*;
#(
   parameter int MAX_DATA_WIDTH = 9,
   parameter int CNT_WIDTH      = 4
) (
   input  logic                 CLK,
   input  logic                 RST,
   uart_frame_serializer_if.slave bus
);

   tx_state_t                 state;
   logic [MAX_DATA_WIDTH-1:0] shift_reg;
   logic [MAX_DATA_WIDTH-1:0] load_data;
   logic [CNT_WIDTH-1:0]      len_r;
   logic [CNT_WIDTH-1:0]      bit_cnt;
   logic [CNT_WIDTH-1:0]      cfg_len_c;
   logic [1:0]                stop_cnt;
   logic [1:0]                stop_target;
   logic                      par_en_r;
   logic                      stop2_r;
   logic                      par_bit_r;
   logic                      par_bit_c;
   logic                      tx_r;
   logic                      busy_r;
   logic                      done_r;
   logic                      last_stop;
   logic                      ready;
   logic                      accept;

   assign stop_target    = stop2_r ? STOP_BITS_TWO : STOP_BITS_ONE;
   assign last_stop      = (state == STOP) && (stop_cnt == stop_target);
   assign ready          = bus.TICK && ((state == IDLE) || last_stop);
   assign accept         = ready && bus.DATA_VALID;

   assign bus.DATA_READY = ready;
   assign bus.TX_OUT     = tx_r;
   assign bus.BUSY       = busy_r;
   assign bus.FRAME_DONE = done_r;

   always_comb begin
      cfg_len_c = bus.CFG_LEN;
      if (bus.CFG_LEN < CNT_WIDTH'(LEN_MIN)) begin
         cfg_len_c = CNT_WIDTH'(LEN_MIN);
      end else if (bus.CFG_LEN > CNT_WIDTH'(MAX_DATA_WIDTH)) begin
         cfg_len_c = CNT_WIDTH'(MAX_DATA_WIDTH);
      end
   end

   // MSB-first words are bit-reversed at load so the shifter always sends bit 0 next.
   always_comb begin
      load_data = bus.P_DATA;
      if (bus.CFG_MSB_FIRST) begin
         load_data = '0;
         for (int i = 0; i < MAX_DATA_WIDTH; i++) begin
            if (i < int'(cfg_len_c)) begin
               load_data[i] = bus.P_DATA[cfg_len_c - CNT_WIDTH'(i) - 1'b1];
            end
         end
      end
   end

   uart_parity_calc #(
      .DATA_WIDTH (MAX_DATA_WIDTH),
      .CNT_WIDTH  (CNT_WIDTH)
   ) u_parity (
      .data   (bus.P_DATA),
      .len    (cfg_len_c),
      .odd    (bus.CFG_PAR_ODD),
      .parity (par_bit_c)
   );

   // Parity is captured at acceptance because the shifter is consumed during DATA.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state     <= IDLE;
         shift_reg <= '0;
         len_r     <= '0;
         bit_cnt   <= '0;
         stop_cnt  <= '0;
         par_en_r  <= 1'b0;
         stop2_r   <= 1'b0;
         par_bit_r <= 1'b0;
         tx_r      <= 1'b1;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
      end else begin
         done_r <= 1'b0;
         if (bus.TICK) begin
            if (last_stop) begin
               done_r <= 1'b1;
            end
            if (accept) begin
               state     <= START;
               busy_r    <= 1'b1;
               tx_r      <= 1'b0;
               shift_reg <= load_data;
               len_r     <= cfg_len_c;
               bit_cnt   <= '0;
               stop_cnt  <= '0;
               par_en_r  <= bus.CFG_PAR_EN;
               stop2_r   <= bus.CFG_STOP2;
               par_bit_r <= par_bit_c;
            end else begin
               case (state)
                  IDLE: begin
                     tx_r <= 1'b1;
                  end
                  START: begin
                     state     <= DATA;
                     tx_r      <= shift_reg[0];
                     shift_reg <= shift_reg >> 1;
                     bit_cnt   <= CNT_WIDTH'(1);
                  end
                  DATA: begin
                     if (bit_cnt == len_r) begin
                        if (par_en_r) begin
                           state <= PARITY;
                           tx_r  <= par_bit_r;
                        end else begin
                           state    <= STOP;
                           tx_r     <= 1'b1;
                           stop_cnt <= STOP_BITS_ONE;
                        end
                     end else begin
                        tx_r      <= shift_reg[0];
                        shift_reg <= shift_reg >> 1;
                        bit_cnt   <= bit_cnt + 1'b1;
                     end
                  end
                  PARITY: begin
                     state    <= STOP;
                     tx_r     <= 1'b1;
                     stop_cnt <= STOP_BITS_ONE;
                  end
                  STOP: begin
                     if (last_stop) begin
                        state  <= IDLE;
                        busy_r <= 1'b0;
                        tx_r   <= 1'b1;
                     end else begin
                        stop_cnt <= stop_cnt + 1'b1;
                     end
                  end
                  default: begin
                     state  <= IDLE;
                     busy_r <= 1'b0;
                     tx_r   <= 1'b1;
                  end
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_frame_serializer.sv
// Scoreboard bench for uart_frame_serializer: stimulus queues hand-computed frames, a monitor checks
// every serial bit and every FRAME_DONE against them.
module tb_uart_frame_serializer;

   localparam int W  = 9;
   localparam int CW = 4;

   logic CLK;
   logic RST;

   uart_frame_serializer_if #(.MAX_DATA_WIDTH(W), .CNT_WIDTH(CW)) bus ();

   uart_frame_serializer #(
      .MAX_DATA_WIDTH (W),
      .CNT_WIDTH      (CW)
   ) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   int   n_checks = 0;
   int   n_fail   = 0;
   logic exp_bits[$];
   int   exp_len[$];
   time  done_t[$];
   int   cur_cnt    = 0;
   int   busy_high  = 0;
   int   busy_low   = 0;
   logic tick_edge  = 1'b0;

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Baud strobe: one clock high out of every four, changed just after the rising edge.
   initial begin
      int phase;
      phase    = 0;
      bus.TICK = 1'b0;
      forever begin
         @(posedge CLK);
         #1;
         phase    = (phase + 1) % 4;
         bus.TICK = (phase == 3);
      end
   end

   initial begin
      forever begin
         @(negedge CLK);
         if (bus.BUSY === 1'b1) busy_high++;
         else busy_low++;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Every bit period starts on a TICK edge; the line is sampled half a clock later while BUSY.
   initial begin
      forever begin
         @(posedge CLK);
         tick_edge = bus.TICK;
         @(negedge CLK);
         if (bus.FRAME_DONE === 1'b1) begin
            done_t.push_back($time);
            checkOutput("frame_done_expected", 32'(exp_len.size() > 0), 1);
            if (exp_len.size() > 0) checkOutput("frame_done_bit_count", cur_cnt, exp_len.pop_front());
            cur_cnt = 0;
         end
         if (tick_edge && bus.BUSY === 1'b1) begin
            checkOutput("tx_bit_expected", 32'(exp_bits.size() > 0), 1);
            if (exp_bits.size() > 0) checkOutput("tx_bit", bus.TX_OUT, exp_bits.pop_front());
            cur_cnt++;
         end
      end
   end

   task automatic pushFrame(input logic [19:0] bits, input int n);
      for (int i = n - 1; i >= 0; i--) exp_bits.push_back(bits[i]);
      exp_len.push_back(n);
   endtask

   task automatic applyStimulus(input logic [8:0] data, input logic [3:0] len, input logic msb,
                                input logic par_en, input logic par_odd, input logic stop2,
                                input logic hold, input logic [19:0] bits, input int n);
      logic got;
      bus.P_DATA        = data;
      bus.CFG_LEN       = len;
      bus.CFG_MSB_FIRST = msb;
      bus.CFG_PAR_EN    = par_en;
      bus.CFG_PAR_ODD   = par_odd;
      bus.CFG_STOP2     = stop2;
      bus.DATA_VALID    = 1'b1;
      pushFrame(bits, n);
      got = 1'b0;
      for (int k = 0; k < 200 && !got; k++) begin
         @(negedge CLK);
         got = (bus.DATA_READY === 1'b1);
      end
      checkOutput("accept_within_budget", 32'(got), 1);
      if (got) begin
         @(posedge CLK);
         #1;
      end
      bus.DATA_VALID = got ? hold : 1'b0;
   endtask

   task automatic waitIdle(input string name);
      logic idle;
      idle = 1'b0;
      for (int k = 0; k < 1000 && !idle; k++) begin
         @(negedge CLK);
         idle = (bus.BUSY === 1'b0) && (exp_bits.size() == 0) && (exp_len.size() == 0);
      end
      checkOutput({name, "_idle_within_budget"}, 32'(idle), 1);
      @(negedge CLK);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: got timeout, expected end of test");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int s0;
      int s1;
      int nd;
      int ticks;
      RST               = 1'b1;
      bus.P_DATA        = '0;
      bus.DATA_VALID    = 1'b0;
      bus.CFG_LEN       = 4'd8;
      bus.CFG_MSB_FIRST = 1'b0;
      bus.CFG_PAR_EN    = 1'b0;
      bus.CFG_PAR_ODD   = 1'b0;
      bus.CFG_STOP2     = 1'b0;
      #2 RST = 1'b0;
      #10;
      checkOutput("reset_tx_out", bus.TX_OUT, 1);
      checkOutput("reset_busy", bus.BUSY, 0);
      checkOutput("reset_frame_done", bus.FRAME_DONE, 0);
      @(negedge CLK);
      RST = 1'b1;

      // Idle: READY follows TICK alone, line stays high.
      for (int k = 0; k < 12; k++) begin
         @(negedge CLK);
         checkOutput("idle_ready", bus.DATA_READY, bus.TICK);
         checkOutput("idle_tx_out", bus.TX_OUT, 1);
         checkOutput("idle_busy", bus.BUSY, 0);
      end

      // 1: LEN=8 LSB-first, no parity, 1 stop
      s0 = busy_high;
      nd = done_t.size();
      applyStimulus(9'h0A5, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 20'b0101001011, 10);
      waitIdle("t1");
      checkOutput("t1_busy_cycles", busy_high - s0, 40);
      checkOutput("t1_done_count", done_t.size() - nd, 1);

      // 2: LEN=7 MSB-first, even parity, 2 stops, upper bits ignored
      applyStimulus(9'h1C1, 4'd7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 20'b01000001011, 11);
      waitIdle("t2");

      // 3: nine ones with odd then even parity
      applyStimulus(9'h1FF, 4'd9, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 20'b011111111101, 12);
      waitIdle("t3_odd");
      applyStimulus(9'h1FF, 4'd9, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 20'b011111111111, 12);
      waitIdle("t3_even");

      // 4: back-to-back with DATA_VALID held
      nd = done_t.size();
      applyStimulus(9'h000, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 20'b0000000001, 10);
      s0 = busy_low;
      applyStimulus(9'h0FF, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 20'b0111111111, 10);
      s1 = busy_low;
      checkOutput("t4_busy_never_drops", s1 - s0, 0);
      waitIdle("t4");
      checkOutput("t4_done_count", done_t.size() - nd, 2);
      if (done_t.size() >= nd + 2) checkOutput("t4_done_spacing", 32'(done_t[nd+1] - done_t[nd]), 400);

      // 5: length clamping
      applyStimulus(9'h1FF, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 20'b0111111, 7);
      waitIdle("t5_len3");
      applyStimulus(9'h1FF, 4'd15, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 20'b01111111111, 11);
      waitIdle("t5_len15");

      // 6a: reset during the fourth data bit
      nd = done_t.size();
      applyStimulus(9'h0A5, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 20'b0101001011, 10);
      ticks = 0;
      for (int k = 0; k < 100 && ticks < 4; k++) begin
         @(negedge CLK);
         if (bus.TICK === 1'b1) ticks++;
      end
      checkOutput("t6_reached_fourth_bit", ticks, 4);
      @(posedge CLK);
      #3;
      RST = 1'b0;
      exp_bits.delete();
      exp_len.delete();
      cur_cnt = 0;
      #1;
      checkOutput("t6_async_tx_out", bus.TX_OUT, 1);
      checkOutput("t6_async_busy", bus.BUSY, 0);
      repeat (3) @(negedge CLK);
      RST = 1'b1;
      repeat (60) @(negedge CLK);
      checkOutput("t6_no_frame_done", done_t.size() - nd, 0);
      checkOutput("t6_after_reset_tx_out", bus.TX_OUT, 1);
      checkOutput("t6_after_reset_busy", bus.BUSY, 0);

      // 6b: config and data changes mid-frame are ignored
      applyStimulus(9'h0A5, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 20'b0101001011, 10);
      repeat (6) @(negedge CLK);
      bus.CFG_MSB_FIRST = 1'b1;
      bus.P_DATA        = 9'h15A;
      bus.CFG_LEN       = 4'd5;
      bus.CFG_PAR_EN    = 1'b1;
      bus.CFG_STOP2     = 1'b1;
      waitIdle("t6_cfg_toggle");

      repeat (4) @(negedge CLK);
      checkOutput("scoreboard_empty", exp_bits.size() + exp_len.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
